fork_join_sched: RTL



---
 rtl/fork_join_sched.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/fork_join_sched.sv
// fork_join_sched: forks NUM_CH countdown channels on start, joins them per the
// latched policy (all / any+kill / none / any-then-wait), waits POST_DLY cycles,
// then pulses done. Optional abort input/output enabled by defining FJS_ABORT_EN.
module fork_join_sched #(
  parameter int NUM_CH   = 3,
  parameter int CNT_W    = 8,
  parameter int POST_DLY = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [1:0]              mode,
  input  logic [NUM_CH-1:0]       ch_en,
  input  logic [NUM_CH*CNT_W-1:0] dly,
`ifdef FJS_ABORT_EN
  input  logic                    abort,
  output logic                    aborted,
`endif
  output logic                    busy,
  output logic [NUM_CH-1:0]       ch_active,
  output logic [NUM_CH-1:0]       ch_done_pulse,
  output logic                    join_done,
  output logic                    all_done,
  output logic                    done
);

  typedef enum logic [1:0] {IDLE, RUN, WAIT, POST} state_t;
  typedef enum logic [1:0] {JOIN_ALL, JOIN_ANY, JOIN_NONE, JOIN_ANY_WAIT} mode_t;

  // Post counter is loaded with POST_DLY-1 so done lands exactly POST_DLY edges later.
  localparam logic [7:0] POST_LOAD = 8'((POST_DLY == 0) ? 0 : POST_DLY - 1);

  state_t              state_reg, state_next;
  mode_t               mode_reg, mode_next;
  logic [7:0]          post_reg, post_next;
  logic                busy_reg, busy_next;
  logic [NUM_CH-1:0]   active_reg, active_next;
  logic [NUM_CH-1:0]   pulse_reg, pulse_next;
  logic                join_reg, join_next;
  logic                all_reg, all_next;
  logic                done_reg, done_next;
  logic                aborted_reg, aborted_next;

  logic [NUM_CH-1:0]   cnt_zero;
  logic [NUM_CH-1:0]   comp;
  logic [NUM_CH-1:0]   remain;
  logic                load;
  logic                counting;
  logic                finish;
  logic                abort_req;

`ifdef FJS_ABORT_EN
  assign abort_req = abort;
  assign aborted   = aborted_reg;
`else
  assign abort_req = 1'b0;
`endif

  assign load     = (state_reg == IDLE) && start;
  assign counting = (state_reg == RUN) || (state_reg == WAIT);

  // One countdown per channel; a channel whose counter is already 0 completes this edge.
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic [CNT_W-1:0] cnt_reg;

    // Load the delay at launch, then decrement while active, saturating at zero.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        cnt_reg <= '0;
      end else if (load) begin
        cnt_reg <= dly[gi*CNT_W +: CNT_W];
      end else if (counting && active_reg[gi] && (cnt_reg != '0)) begin
        cnt_reg <= cnt_reg - 1'b1;
      end
    end

    assign cnt_zero[gi] = (cnt_reg == '0);
  end

  assign comp   = active_reg & cnt_zero;
  assign remain = active_reg & ~comp;

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      mode_reg    <= JOIN_ALL;
      post_reg    <= '0;
      busy_reg    <= 1'b0;
      active_reg  <= '0;
      pulse_reg   <= '0;
      join_reg    <= 1'b0;
      all_reg     <= 1'b0;
      done_reg    <= 1'b0;
      aborted_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      mode_reg    <= mode_next;
      post_reg    <= post_next;
      busy_reg    <= busy_next;
      active_reg  <= active_next;
      pulse_reg   <= pulse_next;
      join_reg    <= join_next;
      all_reg     <= all_next;
      done_reg    <= done_next;
      aborted_reg <= aborted_next;
    end
  end

  // Next-state logic: join policy, post delay and abort override.
  always_comb begin
    state_next   = state_reg;
    mode_next    = mode_reg;
    post_next    = post_reg;
    busy_next    = busy_reg;
    active_next  = active_reg;
    pulse_next   = '0;
    join_next    = 1'b0;
    all_next     = 1'b0;
    done_next    = 1'b0;
    aborted_next = 1'b0;
    finish       = 1'b0;

    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next  = RUN;
          mode_next   = mode_t'(mode);
          busy_next   = 1'b1;
          active_next = ch_en;
        end
      end
      RUN: begin
        active_next = remain;
        pulse_next  = comp;
        case (mode_reg)
          JOIN_ALL: begin
            if (remain == '0) begin
              join_next = 1'b1;
              finish    = 1'b1;
            end
          end
          JOIN_ANY: begin
            // First completion (ties included) wins; everything still counting is killed.
            if ((comp != '0) || (active_reg == '0)) begin
              join_next   = 1'b1;
              finish      = 1'b1;
              active_next = '0;
            end
          end
          JOIN_NONE: begin
            join_next = 1'b1;
            if (remain == '0) finish = 1'b1;
            else              state_next = WAIT;
          end
          JOIN_ANY_WAIT: begin
            if ((comp != '0) || (active_reg == '0)) begin
              join_next = 1'b1;
              if (remain == '0) finish = 1'b1;
              else              state_next = WAIT;
            end
          end
        endcase
      end
      WAIT: begin
        active_next = remain;
        pulse_next  = comp;
        if (remain == '0) finish = 1'b1;
      end
      POST: begin
        if (post_reg == '0) begin
          done_next  = 1'b1;
          busy_next  = 1'b0;
          state_next = IDLE;
        end else begin
          post_next = post_reg - 1'b1;
        end
      end
    endcase

    // Final completion: enter the post phase, or finish at once when it is empty.
    if (finish) begin
      all_next = 1'b1;
      if (POST_DLY == 0) begin
        done_next  = 1'b1;
        busy_next  = 1'b0;
        state_next = IDLE;
      end else begin
        post_next  = POST_LOAD;
        state_next = POST;
      end
    end

    // Abort wins over every pending event while a launch is in flight.
    if (abort_req && (state_reg != IDLE)) begin
      state_next   = IDLE;
      busy_next    = 1'b0;
      active_next  = '0;
      pulse_next   = '0;
      join_next    = 1'b0;
      all_next     = 1'b0;
      done_next    = 1'b0;
      aborted_next = 1'b1;
    end
  end

  assign busy          = busy_reg;
  assign ch_active     = active_reg;
  assign ch_done_pulse = pulse_reg;
  assign join_done     = join_reg;
  assign all_done      = all_reg;
  assign done          = done_reg;

endmodule
